// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } port_state_t;

  localparam int WAIT_CNT_W = 4;
  localparam logic [15:0] FILL_WORD_DEFAULT = 16'hABCD;

endpackage

// File: rtl/mem_port_seq.sv
// Per-port wait-state sequencer: request latch, wait counter and IDLE/BUSY/DONE FSM.
module mem_port_seq
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BYTES       = DATA_W / 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [BYTES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              commit,
  output logic              ready,
  output logic [ADDR_W-1:0] addr_q,
  output logic [BYTES-1:0]  we_q,
  output logic [DATA_W-1:0] wdata_q
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  port_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: accept = req;
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        if (req) accept = 1'b1;
        else     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // DONE accepts a new request exactly like IDLE
    if (accept) begin
      state_d = BUSY;
      cnt_d   = WAIT_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
    end
  end

endmodule

// File: rtl/wait_state_memory.sv
// Two-port byte-lane memory with programmable wait states; port 1 read-only, port 2 read/write.
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] FILL_WORD   = FILL_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p1_req,
  input  logic [ADDR_W-1:0]     p1_addr,
  output logic                  p1_ready,
  output logic [DATA_W-1:0]     p1_rdata,
  input  logic                  p2_req,
  input  logic [DATA_W/8-1:0]   p2_we,
  input  logic [ADDR_W-1:0]     p2_addr,
  input  logic [DATA_W-1:0]     p2_wdata,
  output logic                  p2_ready,
  output logic [DATA_W-1:0]     p2_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = ADDR_W - LSB;
  localparam int DEPTH = 1 << IDX_W;
  localparam int REPS  = (DATA_W + 15) / 16;
  localparam logic [16*REPS-1:0] FILL_REP = {REPS{FILL_WORD}};

  if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_width
    $error("wait_state_memory: DATA_W must be a positive multiple of 8");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("wait_state_memory: WAIT_CYCLES must be in 0..15");
  end

  logic              p1_commit, p2_commit;
  logic [ADDR_W-1:0] p1_addr_q, p2_addr_q;
  logic [BYTES-1:0]  p1_we_q, p2_we_q;
  logic [DATA_W-1:0] p1_wdata_q, p2_wdata_q;
  logic [DATA_W-1:0] p1_word, p2_word;
  logic [IDX_W-1:0]  p1_idx, p2_idx;
  logic              unused_bits;

  mem_port_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTES(BYTES), .WAIT_CYCLES(WAIT_CYCLES)) u_p1 (
    .clk     (clk),
    .rst     (rst),
    .req     (p1_req),
    .we      ('0),
    .addr    (p1_addr),
    .wdata   ('0),
    .commit  (p1_commit),
    .ready   (p1_ready),
    .addr_q  (p1_addr_q),
    .we_q    (p1_we_q),
    .wdata_q (p1_wdata_q)
  );

  mem_port_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTES(BYTES), .WAIT_CYCLES(WAIT_CYCLES)) u_p2 (
    .clk     (clk),
    .rst     (rst),
    .req     (p2_req),
    .we      (p2_we),
    .addr    (p2_addr),
    .wdata   (p2_wdata),
    .commit  (p2_commit),
    .ready   (p2_ready),
    .addr_q  (p2_addr_q),
    .we_q    (p2_we_q),
    .wdata_q (p2_wdata_q)
  );

  assign p1_idx      = p1_addr_q[ADDR_W-1:LSB];
  assign p2_idx      = p2_addr_q[ADDR_W-1:LSB];
  assign unused_bits = ^{p1_we_q, p1_wdata_q, p1_addr_q, p2_addr_q};

  // Non-blocking lane update gives read-first behaviour for both ports on a shared commit edge
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    logic [7:0] lane [DEPTH] = '{default: FILL_REP[8*i +: 8]};
    logic [7:0] p1_byte_q, p2_byte_q;

    always_ff @(posedge clk) begin
      if (p1_commit) p1_byte_q <= lane[p1_idx];
      if (p2_commit) begin
        p2_byte_q <= lane[p2_idx];
        if (p2_we_q[i]) lane[p2_idx] <= p2_wdata_q[8*i +: 8];
      end
    end

    assign p1_word[8*i +: 8] = p1_byte_q;
    assign p2_word[8*i +: 8] = p2_byte_q;
  end

  // Gating with ready keeps rdata zero outside the pulse and clears it asynchronously on reset
  assign p1_rdata = p1_ready ? p1_word : '0;
  assign p2_rdata = p2_ready ? p2_word : '0;

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench for wait_state_memory: timestamped transaction model plus directed literal checks.
module tb_wait_state_memory;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        p1_req, p2_req;
  logic [15:0] p1_addr, p2_addr, p2_wdata, p1_rdata, p2_rdata;
  logic [1:0]  p2_we;
  logic        p1_ready, p2_ready;

  logic        z_p1_req, z_p2_req, z_p1_ready, z_p2_ready;
  logic [15:0] z_p1_addr, z_p2_addr, z_p2_wdata, z_p1_rdata, z_p2_rdata;
  logic [1:0]  z_p2_we;

  always #5 clk = ~clk;

  wait_state_memory #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W), .FILL_WORD(16'hABCD)) dut (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ready(p2_ready), .p2_rdata(p2_rdata)
  );

  wait_state_memory #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0), .FILL_WORD(16'hABCD)) dut_z (
    .clk(clk), .rst(rst),
    .p1_req(z_p1_req), .p1_addr(z_p1_addr), .p1_ready(z_p1_ready), .p1_rdata(z_p1_rdata),
    .p2_req(z_p2_req), .p2_we(z_p2_we), .p2_addr(z_p2_addr), .p2_wdata(z_p2_wdata),
    .p2_ready(z_p2_ready), .p2_rdata(z_p2_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus one outstanding transaction per port, each stamped
  // with the edge at which it must commit (accept edge + W + 1).
  typedef struct {
    bit          v;
    int          ce;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wd;
  } txn_t;

  logic [15:0] mmem [int];
  txn_t        pend1, pend2;
  int          edge_n = 0;
  logic        e_rdy1, e_rdy2;
  logic [15:0] e_rd1, e_rd2;

  function automatic logic [15:0] mrd(input int idx);
    return mmem.exists(idx) ? mmem[idx] : 16'hABCD;
  endfunction

  always @(posedge clk) begin
    bit          acc1, acc2;
    logic [15:0] w;
    edge_n++;
    e_rdy1 = 1'b0; e_rdy2 = 1'b0; e_rd1 = '0; e_rd2 = '0;
    if (rst) begin
      pend1.v = 1'b0;
      pend2.v = 1'b0;
    end else begin
      acc1 = p1_req && !pend1.v;
      acc2 = p2_req && !pend2.v;
      if (pend1.v && pend1.ce == edge_n) begin
        e_rdy1 = 1'b1;
        e_rd1  = mrd(int'(pend1.addr >> 1));
        pend1.v = 1'b0;
      end
      if (pend2.v && pend2.ce == edge_n) begin
        w      = mrd(int'(pend2.addr >> 1));
        e_rdy2 = 1'b1;
        e_rd2  = w;
        for (int b = 0; b < 2; b++)
          if (pend2.we[b]) w[8*b +: 8] = pend2.wd[8*b +: 8];
        mmem[int'(pend2.addr >> 1)] = w;
        pend2.v = 1'b0;
      end
      if (acc1) pend1 = '{v: 1'b1, ce: edge_n + W + 1, we: 2'b00, addr: p1_addr, wd: 16'h0};
      if (acc2) pend2 = '{v: 1'b1, ce: edge_n + W + 1, we: p2_we, addr: p2_addr, wd: p2_wdata};
    end
    #1;
    chk("p1_ready", {31'b0, p1_ready}, {31'b0, e_rdy1});
    chk("p1_rdata", {16'b0, p1_rdata}, {16'b0, e_rd1});
    chk("p2_ready", {31'b0, p2_ready}, {31'b0, e_rdy2});
    chk("p2_rdata", {16'b0, p2_rdata}, {16'b0, e_rd2});
  end

  logic [15:0] r1, r2;
  int          l1, l2;

  task automatic go(input bit d1, input logic [15:0] a1, input bit d2, input logic [1:0] we2,
                    input logic [15:0] a2, input logic [15:0] wd2);
    @(negedge clk);
    p1_req = d1; p1_addr = a1;
    p2_req = d2; p2_we = we2; p2_addr = a2; p2_wdata = wd2;
    @(negedge clk);
    p1_req = 1'b0; p2_req = 1'b0;
    p1_addr = 16'($urandom); p2_addr = 16'($urandom);
    p2_we = 2'($urandom); p2_wdata = 16'($urandom);
    l1 = -1; l2 = -1; r1 = '0; r2 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (p1_ready && l1 < 0) begin l1 = i; r1 = p1_rdata; end
      if (p2_ready && l2 < 0) begin l2 = i; r2 = p2_rdata; end
      if ((!d1 || l1 >= 0) && (!d2 || l2 >= 0)) break;
    end
  endtask

  initial begin
    int          pulses;
    logic [31:0] mask;

    rst = 1'b1;
    p1_req = 1'b0; p1_addr = '0; p2_req = 1'b0; p2_we = '0; p2_addr = '0; p2_wdata = '0;
    z_p1_req = 1'b0; z_p1_addr = '0; z_p2_req = 1'b0; z_p2_we = '0; z_p2_addr = '0; z_p2_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_p1_ready", {31'b0, p1_ready}, 32'd0);
    chk("reset_p2_rdata", {16'b0, p2_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // power-up read and latency
    go(1'b1, 16'h3000, 1'b0, 2'b00, 16'h0, 16'h0);
    chk("powerup_lat", l1, 32'd3);
    chk("powerup_data", {16'b0, r1}, 32'hABCD);

    // low-lane write, then read back via odd byte address
    go(1'b0, 16'h0, 1'b1, 2'b01, 16'h0040, 16'h1234);
    chk("lane_wr_lat", l2, 32'd3);
    chk("lane_wr_old", {16'b0, r2}, 32'hABCD);
    go(1'b1, 16'h0041, 1'b0, 2'b00, 16'h0, 16'h0);
    chk("lane_rd", {16'b0, r1}, 32'hAB34);

    // same-edge read/write conflict
    go(1'b1, 16'h0100, 1'b1, 2'b11, 16'h0100, 16'h5555);
    chk("conflict_p1", {16'b0, r1}, 32'hABCD);
    chk("conflict_p2", {16'b0, r2}, 32'hABCD);
    go(1'b1, 16'h0100, 1'b0, 2'b00, 16'h0, 16'h0);
    chk("conflict_after", {16'b0, r1}, 32'h5555);

    // back-to-back with req held for 12 edges, address churning every cycle
    mask = '0;
    @(negedge clk);
    p1_req = 1'b1; p1_addr = 16'h0040;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #2;
      if (p1_ready) mask[c] = 1'b1;
      @(negedge clk);
      if (c == 11) p1_req = 1'b0;
      p1_addr = 16'($urandom_range(0, 16'h0103));
    end
    chk("b2b_mask", mask, 32'h0000_0888);

    // reset during BUSY of a write aborts it
    @(negedge clk);
    p2_req = 1'b1; p2_we = 2'b11; p2_addr = 16'h0200; p2_wdata = 16'hFFFF;
    @(negedge clk);
    p2_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_ready", {31'b0, p2_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #2;
      if (p2_ready) pulses++;
    end
    chk("rst_busy_pulses", pulses, 32'd0);
    go(1'b1, 16'h0200, 1'b0, 2'b00, 16'h0, 16'h0);
    chk("rst_busy_reread", {16'b0, r1}, 32'hABCD);

    // reset during DONE clears outputs at once but the write stays
    go(1'b0, 16'h0, 1'b1, 2'b11, 16'h0300, 16'h1357);
    chk("done_lat", l2, 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_done_ready", {31'b0, p2_ready}, 32'd0);
    chk("rst_done_rdata", {16'b0, p2_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    go(1'b1, 16'h0300, 1'b0, 2'b00, 16'h0, 16'h0);
    chk("rst_done_reread", {16'b0, r1}, 32'h1357);

    // zero-wait build: write then read on consecutive accepts
    @(negedge clk);
    z_p2_req = 1'b1; z_p2_we = 2'b11; z_p2_addr = 16'h0080; z_p2_wdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    z_p2_we = 2'b00; z_p2_wdata = 16'h0000;
    @(posedge clk); #2;
    chk("z_wr_ready", {31'b0, z_p2_ready}, 32'd1);
    chk("z_wr_old", {16'b0, z_p2_rdata}, 32'hABCD);
    @(posedge clk); #2;
    chk("z_gap_ready", {31'b0, z_p2_ready}, 32'd0);
    @(negedge clk);
    z_p2_req = 1'b0;
    @(posedge clk); #2;
    chk("z_rd_ready", {31'b0, z_p2_ready}, 32'd1);
    chk("z_rd_data", {16'b0, z_p2_rdata}, 32'hBEEF);
    @(posedge clk); #2;
    chk("z_idle_rdata", {16'b0, z_p2_rdata}, 32'd0);

    // randomized traffic on a small address window to force conflicts
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) == 0);
      p1_req   = 1'($urandom);
      p1_addr  = 16'($urandom_range(0, 15));
      p2_req   = 1'($urandom);
      p2_we    = 2'($urandom);
      p2_addr  = 16'($urandom_range(0, 15));
      p2_wdata = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
